// File: rtl/pong_frame_engine.sv
// Pong game state and pixel colour stage behind the VGA sync generator.
// Ports: clk, rst_n, raster in (CounterX/Y, inDisplayArea), buttons in,
//   registered vga_R/G/B out, hit_count, miss_count, game_state out.
module pong_frame_engine #(
  parameter int BALL_SIZE   = 16,
  parameter int BALL_STEP   = 2,
  parameter int PADDLE_W    = 64,
  parameter int PADDLE_STEP = 4,
  parameter int MISS_HOLD   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] CounterX,
  input  logic [8:0] CounterY,
  input  logic       inDisplayArea,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_serve,
  output logic       vga_R,
  output logic       vga_G,
  output logic       vga_B,
  output logic [7:0] hit_count,
  output logic [3:0] miss_count,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_MISS  = 2'd2
  } state_e;

  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] BSTEP  = 11'(BALL_STEP);
  localparam logic [10:0] PW     = 11'(PADDLE_W);
  localparam logic [10:0] PSTEP  = 11'(PADDLE_STEP);
  localparam logic [10:0] BX0    = 11'd312;
  localparam logic [10:0] BY0    = 11'd232;
  localparam logic [10:0] PX0    = 11'd288;
  localparam logic [10:0] EDGE_L = 11'd8;
  localparam logic [10:0] EDGE_R = 11'd632;
  localparam logic [10:0] EDGE_T = 11'd8;
  localparam logic [10:0] PAD_T  = 11'd464;
  localparam logic [10:0] PAD_B  = 11'd471;
  localparam logic [10:0] LOST_Y = 11'd472;
  localparam logic [10:0] PX_MIN = 11'd8;
  localparam logic [10:0] PX_MAX = 11'd568;
  localparam logic [6:0]  MC_END = 7'(MISS_HOLD - 1);

  state_e      state_q, state_d;
  logic [10:0] bx_q, bx_d, by_q, by_d, px_q, px_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [7:0]  hit_q, hit_d;
  logic [3:0]  miss_q, miss_d;
  logic [6:0]  mc_q, mc_d;
  logic [2:0]  rgb_q, rgb_d;

  logic        tick, hit, ndx, ndy;
  logic [10:0] nbx, nby, pix_x, pix_y;
  logic        ball_on, pad_on, brd_on;

  assign tick  = (CounterX == 10'd0) && (CounterY == 9'd480);
  assign pix_x = {1'b0, CounterX};
  assign pix_y = {2'b0, CounterY};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SERVE;
      bx_q    <= BX0;
      by_q    <= BY0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b0;
      px_q    <= PX0;
      hit_q   <= 8'd0;
      miss_q  <= 4'd0;
      mc_q    <= 7'd0;
      rgb_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      px_q    <= px_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      mc_q    <= mc_d;
      rgb_q   <= rgb_d;
    end
  end

  // dx/dy: 1 = moving toward larger coordinate.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    px_d    = px_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    mc_d    = mc_q;
    hit     = 1'b0;
    ndx     = dx_q;
    ndy     = dy_q;
    nbx     = bx_q;
    nby     = by_q;
    if (tick) begin
      if (btn_left && !btn_right) begin
        px_d = (px_q >= PX_MIN + PSTEP) ? px_q - PSTEP : PX_MIN;
      end else if (btn_right && !btn_left) begin
        px_d = (px_q + PSTEP <= PX_MAX) ? px_q + PSTEP : PX_MAX;
      end
      unique case (state_q)
        S_SERVE: begin
          bx_d = BX0;
          by_d = BY0;
          dx_d = 1'b1;
          dy_d = 1'b0;
          if (btn_serve) state_d = S_PLAY;
        end
        S_PLAY: begin
          if (bx_q <= EDGE_L) ndx = 1'b1;
          if (bx_q + BS >= EDGE_R) ndx = 1'b0;
          if (by_q <= EDGE_T) ndy = 1'b1;
          hit = dy_q
              && (by_q + BS >= PAD_T) && (by_q + BS <= PAD_B)
              && (bx_q + BS > px_q) && (bx_q < px_q + PW);
          if (hit) begin
            ndy   = 1'b0;
            hit_d = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
          end
          nbx  = ndx ? bx_q + BSTEP : bx_q - BSTEP;
          nby  = ndy ? by_q + BSTEP : by_q - BSTEP;
          bx_d = nbx;
          by_d = nby;
          dx_d = ndx;
          dy_d = ndy;
          if (nby >= LOST_Y) begin
            state_d = S_MISS;
            miss_d  = miss_q + 4'd1;
            mc_d    = 7'd0;
          end
        end
        S_MISS: begin
          if (mc_q == MC_END) begin
            state_d = S_SERVE;
            mc_d    = 7'd0;
            bx_d    = BX0;
            by_d    = BY0;
            dx_d    = 1'b1;
            dy_d    = 1'b0;
          end else begin
            mc_d = mc_q + 7'd1;
          end
        end
        default: state_d = S_SERVE;
      endcase
    end
  end

  always_comb begin
    ball_on = (state_q != S_MISS)
            && (pix_x >= bx_q) && (pix_x < bx_q + BS)
            && (pix_y >= by_q) && (pix_y < by_q + BS);
    pad_on  = (pix_y >= PAD_T) && (pix_y <= PAD_B)
            && (pix_x >= px_q) && (pix_x < px_q + PW);
    brd_on  = (pix_x < EDGE_L) || (pix_x >= EDGE_R)
            || (pix_y < EDGE_T);
    rgb_d   = 3'b000;
    if (inDisplayArea) begin
      if (ball_on)     rgb_d = 3'b100;
      else if (pad_on) rgb_d = 3'b010;
      else if (brd_on) rgb_d = 3'b111;
    end
  end

  assign vga_R      = rgb_q[2];
  assign vga_G      = rgb_q[1];
  assign vga_B      = rgb_q[0];
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_pong_frame_engine.sv
// Self-checking bench for pong_frame_engine: drives raster points and
// frame ticks directly, checks against a frame-level game model.
module tb_pong_frame_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic       inDisplayArea;
  logic       btn_left, btn_right, btn_serve;
  logic       vga_R, vga_G, vga_B;
  logic [7:0] hit_count;
  logic [3:0] miss_count;
  logic [1:0] game_state;

  int n_checks = 0;
  int n_fail   = 0;

  // frame-level model
  int m_state, m_bx, m_by, m_dx, m_dy, m_px;
  int m_hit, m_miss, m_hold;

  pong_frame_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .CounterX      (CounterX),
    .CounterY      (CounterY),
    .inDisplayArea (inDisplayArea),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_serve     (btn_serve),
    .vga_R         (vga_R),
    .vga_G         (vga_G),
    .vga_B         (vga_B),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .game_state    (game_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0;
    m_bx = 312; m_by = 232;
    m_dx = 1;   m_dy = -1;
    m_px = 288;
    m_hit = 0; m_miss = 0; m_hold = 0;
  endtask

  task automatic model_frame(input bit l, input bit r, input bit s);
    int hit;
    if (m_state == 0) begin
      m_bx = 312; m_by = 232; m_dx = 1; m_dy = -1;
      if (s) m_state = 1;
    end else if (m_state == 1) begin
      if (m_bx <= 8) m_dx = 1;
      if (m_bx + 16 >= 632) m_dx = -1;
      if (m_by <= 8) m_dy = 1;
      hit = 0;
      if (m_dy == 1 && m_by + 16 >= 464 && m_by + 16 <= 471 &&
          m_bx + 16 > m_px && m_bx < m_px + 64) hit = 1;
      if (hit != 0) begin
        m_dy = -1;
        if (m_hit < 255) m_hit++;
      end
      m_bx += 2 * m_dx;
      m_by += 2 * m_dy;
      if (m_by >= 472) begin
        m_state = 2;
        m_miss = (m_miss + 1) % 16;
        m_hold = 0;
      end
    end else begin
      m_hold++;
      if (m_hold == 64) begin
        m_state = 0;
        m_bx = 312; m_by = 232; m_dx = 1; m_dy = -1;
      end
    end
    if (l && !r) m_px = (m_px - 4 < 8) ? 8 : m_px - 4;
    if (r && !l) m_px = (m_px + 4 > 568) ? 568 : m_px + 4;
  endtask

  function automatic logic [2:0] exp_rgb(input int x, input int y,
                                         input bit da);
    if (!da) return 3'b000;
    if (m_state != 2 && x >= m_bx && x < m_bx + 16 &&
        y >= m_by && y < m_by + 16) return 3'b100;
    if (y >= 464 && y <= 471 && x >= m_px && x < m_px + 64)
      return 3'b010;
    if (x < 8 || x >= 632 || y < 8) return 3'b111;
    return 3'b000;
  endfunction

  task automatic park();
    CounterX = 10'd700;
    CounterY = 9'd500;
    inDisplayArea = 1'b0;
  endtask

  task automatic frame(input bit l, input bit r, input bit s);
    btn_left = l; btn_right = r; btn_serve = s;
    CounterX = 10'd0;
    CounterY = 9'd480;
    inDisplayArea = 1'b0;
    @(posedge clk);
    #1;
    model_frame(l, r, s);
    park();
    btn_left = 1'b0; btn_right = 1'b0; btn_serve = 1'b0;
  endtask

  task automatic probe(input int x, input int y, input bit da,
                       output logic [2:0] rgb);
    CounterX = 10'(x);
    CounterY = 9'(y);
    inDisplayArea = da;
    @(posedge clk);
    #1;
    rgb = {vga_R, vga_G, vga_B};
    park();
  endtask

  task automatic test_reset();
    logic [2:0] c;
    rst_n = 1'b0;
    park();
    btn_left = 0; btn_right = 0; btn_serve = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (game_state !== 2'd0 || hit_count !== 8'd0 ||
        miss_count !== 4'd0 || {vga_R, vga_G, vga_B} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: st=%0d hit=%0d miss=%0d rgb=%b want 0 0 0 000",
               game_state, hit_count, miss_count, {vga_R, vga_G, vga_B});
    end
    #2 rst_n = 1'b1;
    probe(320, 240, 1'b1, c);
    n_checks++;
    if (c !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ball_pixel: got %b want 100", c);
    end
    probe(300, 466, 1'b1, c);
    n_checks++;
    if (c !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_paddle_pixel: got %b want 010", c);
    end
    probe(2, 100, 1'b1, c);
    n_checks++;
    if (c !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_border_pixel: got %b want 111", c);
    end
  endtask

  task automatic test_paddle_clamp();
    logic [2:0] c;
    repeat (100) frame(1, 0, 0);
    probe(10, 466, 1'b1, c);
    n_checks++;
    if (c !== 3'b010) begin
      n_fail++;
      $display("FAIL clamp_left_x10: got %b want 010", c);
    end
    probe(72, 466, 1'b1, c);
    n_checks++;
    if (c !== 3'b000) begin
      n_fail++;
      $display("FAIL clamp_left_x72: got %b want 000", c);
    end
    repeat (5) frame(1, 1, 0);
    probe(71, 466, 1'b1, c);
    n_checks++;
    if (c !== 3'b010) begin
      n_fail++;
      $display("FAIL both_buttons_x71: got %b want 010", c);
    end
    probe(10, 466, 1'b0, c);
    n_checks++;
    if (c !== 3'b000) begin
      n_fail++;
      $display("FAIL display_off: got %b want 000", c);
    end
    repeat (200) frame(0, 1, 0);
    probe(631, 466, 1'b1, c);
    n_checks++;
    if (c !== 3'b010) begin
      n_fail++;
      $display("FAIL clamp_right_x631: got %b want 010", c);
    end
    probe(567, 466, 1'b1, c);
    n_checks++;
    if (c !== 3'b000) begin
      n_fail++;
      $display("FAIL clamp_right_x567: got %b want 000", c);
    end
  endtask

  task automatic test_serve_flight();
    logic [2:0] c;
    frame(0, 0, 1);
    n_checks++;
    if (game_state !== 2'd1) begin
      n_fail++;
      $display("FAIL serve_state: got %0d want 1", game_state);
    end
    repeat (10) frame(0, 0, 0);
    probe(332, 212, 1'b1, c);
    n_checks++;
    if (c !== 3'b100) begin
      n_fail++;
      $display("FAIL flight_corner_in: got %b want 100", c);
    end
    probe(331, 212, 1'b1, c);
    n_checks++;
    if (c !== 3'b000) begin
      n_fail++;
      $display("FAIL flight_left_out: got %b want 000", c);
    end
    probe(347, 227, 1'b1, c);
    n_checks++;
    if (c !== 3'b100) begin
      n_fail++;
      $display("FAIL flight_far_in: got %b want 100", c);
    end
    probe(348, 228, 1'b1, c);
    n_checks++;
    if (c !== 3'b000) begin
      n_fail++;
      $display("FAIL flight_far_out: got %b want 000", c);
    end
    n_checks++;
    if (hit_count !== 8'd0) begin
      n_fail++;
      $display("FAIL flight_hits: got %0d want 0", hit_count);
    end
  endtask

  task automatic test_random_play(input int frames);
    logic [2:0] c, e;
    int x, y, pc, bc;
    bit l, r, s, da;
    for (int i = 0; i < frames; i++) begin
      pc = m_px + 32;
      bc = m_bx + 8;
      l = (pc > bc + 4);
      r = (pc + 4 < bc);
      if ($urandom_range(0, 9) == 0) begin
        l = 1'($urandom);
        r = 1'($urandom);
      end
      s = ($urandom_range(0, 3) == 0);
      frame(l, r, s);
      n_checks++;
      if (game_state !== 2'(m_state) || hit_count !== 8'(m_hit) ||
          miss_count !== 4'(m_miss)) begin
        n_fail++;
        $display("FAIL play_state f%0d: st=%0d hit=%0d miss=%0d want %0d %0d %0d",
                 i, game_state, hit_count, miss_count,
                 m_state, m_hit, m_miss);
      end
      x = m_bx - 1 + $urandom_range(0, 17);
      y = m_by - 1 + $urandom_range(0, 17);
      if (y < 0) y = 0;
      if (x < 1) x = 1;
      da = ($urandom_range(0, 9) != 0);
      probe(x, y, da, c);
      e = exp_rgb(x, y, da);
      n_checks++;
      if (c !== e) begin
        n_fail++;
        $display("FAIL play_pixel f%0d (%0d,%0d): got %b want %b",
                 i, x, y, c, e);
      end
      x = m_px - 2 + $urandom_range(0, 67);
      y = 462 + $urandom_range(0, 11);
      probe(x, y, 1'b1, c);
      e = exp_rgb(x, y, 1'b1);
      n_checks++;
      if (c !== e) begin
        n_fail++;
        $display("FAIL paddle_pixel f%0d (%0d,%0d): got %b want %b",
                 i, x, y, c, e);
      end
    end
  endtask

  task automatic test_reset_midplay();
    logic [2:0] c;
    CounterX = 10'd2;
    CounterY = 9'd100;
    inDisplayArea = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (game_state !== 2'd0 || hit_count !== 8'd0 ||
        miss_count !== 4'd0 || {vga_R, vga_G, vga_B} !== 3'b000) begin
      n_fail++;
      $display("FAIL midplay_reset: st=%0d hit=%0d miss=%0d rgb=%b want 0 0 0 000",
               game_state, hit_count, miss_count, {vga_R, vga_G, vga_B});
    end
    park();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    probe(312, 232, 1'b1, c);
    n_checks++;
    if (c !== 3'b100) begin
      n_fail++;
      $display("FAIL post_reset_ball: got %b want 100", c);
    end
    probe(311, 232, 1'b1, c);
    n_checks++;
    if (c !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_ball_edge: got %b want 000", c);
    end
    frame(0, 0, 0);
    n_checks++;
    if (game_state !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_state: got %0d want 0", game_state);
    end
  endtask

  initial begin
    test_reset();
    test_paddle_clamp();
    test_serve_flight();
    test_random_play(2500);
    test_reset_midplay();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
